// File: rtl/z80_dbg_pkg.sv
// Shared layout constants, state encoding and snapshot record for the register panel formatter.
// Z80_FMT_ALTREG_EN adds the alternate register row (BC', DE', HL') to the panel.
package z80_dbg_pkg;

  localparam int PANEL_COLS = 24;
`ifdef Z80_FMT_ALTREG_EN
  localparam int PANEL_ROWS = 4;
`else
  localparam int PANEL_ROWS = 3;
`endif
  localparam int PANEL_LAST = PANEL_ROWS * PANEL_COLS - 1;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_APOS  = 8'h27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } fmt_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
    logic [15:0] ix;
    logic [15:0] iy;
    logic [7:0]  ac;
    logic        z;
    logic        n;
    logic        p;
    logic        c;
`ifdef Z80_FMT_ALTREG_EN
    logic [15:0] bc_alt;
    logic [15:0] de_alt;
    logic [15:0] hl_alt;
`endif
  } snap_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    else           return 8'h41 + 8'(n) - 8'd10;
  endfunction

endpackage

// File: rtl/z80_fmt_charrom.sv
// Combinational character generator: maps a panel (row, col) and register snapshot to ASCII.
// Z80_FMT_ALTREG_EN enables row 3 (alternate register set).
module z80_fmt_charrom
  import z80_dbg_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [4:0] col_i,
  input  snap_t      snap_i,
  output logic [7:0] char_o
);

  // Every row is three 8-column groups; most groups are "LL:hhhh " register fields.
  logic [1:0]  grp;
  logic [2:0]  off;
  logic [15:0] word;
  logic [7:0]  lbl0;
  logic [7:0]  lbl1;
  logic [7:0]  sep;
  logic        is_word;

  always_comb begin
    grp     = col_i[4:3];
    off     = col_i[2:0];
    word    = '0;
    lbl0    = ASC_SPACE;
    lbl1    = ASC_SPACE;
    sep     = ASC_COLON;
    is_word = 1'b0;
    char_o  = ASC_SPACE;

    case ({row_i, grp})
      4'b00_00: begin word = snap_i.pc; lbl0 = "P"; lbl1 = "C"; is_word = 1'b1; end
      4'b00_01: begin word = snap_i.sp; lbl0 = "S"; lbl1 = "P"; is_word = 1'b1; end
      4'b01_00: begin word = snap_i.bc; lbl0 = "B"; lbl1 = "C"; is_word = 1'b1; end
      4'b01_01: begin word = snap_i.de; lbl0 = "D"; lbl1 = "E"; is_word = 1'b1; end
      4'b01_10: begin word = snap_i.hl; lbl0 = "H"; lbl1 = "L"; is_word = 1'b1; end
      4'b10_00: begin word = snap_i.ix; lbl0 = "I"; lbl1 = "X"; is_word = 1'b1; end
      4'b10_01: begin word = snap_i.iy; lbl0 = "I"; lbl1 = "Y"; is_word = 1'b1; end
`ifdef Z80_FMT_ALTREG_EN
      4'b11_00: begin word = snap_i.bc_alt; lbl0 = "B"; lbl1 = "C"; sep = ASC_APOS; is_word = 1'b1; end
      4'b11_01: begin word = snap_i.de_alt; lbl0 = "D"; lbl1 = "E"; sep = ASC_APOS; is_word = 1'b1; end
      4'b11_10: begin word = snap_i.hl_alt; lbl0 = "H"; lbl1 = "L"; sep = ASC_APOS; is_word = 1'b1; end
`endif
      default: ;
    endcase

    if (is_word) begin
      case (off)
        3'd0: char_o = lbl0;
        3'd1: char_o = lbl1;
        3'd2: char_o = sep;
        3'd3: char_o = hex_ascii(word[15:12]);
        3'd4: char_o = hex_ascii(word[11:8]);
        3'd5: char_o = hex_ascii(word[7:4]);
        3'd6: char_o = hex_ascii(word[3:0]);
        default: char_o = ASC_SPACE;
      endcase
    end else if (row_i == 2'd0 && grp == 2'd2) begin
      case (off)
        3'd0: char_o = "A";
        3'd1: char_o = ASC_COLON;
        3'd2: char_o = hex_ascii(snap_i.ac[7:4]);
        3'd3: char_o = hex_ascii(snap_i.ac[3:0]);
        default: char_o = ASC_SPACE;
      endcase
    end else if (row_i == 2'd2 && grp == 2'd2) begin
      case (off)
        3'd0: char_o = "F";
        3'd1: char_o = ASC_COLON;
        3'd2: char_o = snap_i.z ? 8'h5A : ASC_DASH;
        3'd3: char_o = snap_i.n ? 8'h4E : ASC_DASH;
        3'd4: char_o = snap_i.p ? 8'h50 : ASC_DASH;
        3'd5: char_o = snap_i.c ? 8'h43 : ASC_DASH;
        default: char_o = ASC_SPACE;
      endcase
    end
  end

endmodule

// File: rtl/z80_reg_formatter.sv
// Snapshots Z80 debugger registers on start and streams them as an ASCII panel over valid/ready.
// Z80_FMT_ALTREG_EN adds BC_alt/DE_alt/HL_alt ports and a fourth panel row.
//   state  | meaning
//   IDLE   | waiting for start; snapshot frozen
//   EMIT   | presenting panel character at (row, col)
//   FINISH | one-cycle done pulse
module z80_reg_formatter
  import z80_dbg_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] PC,
  input  logic [15:0] SP,
  input  logic [15:0] BC,
  input  logic [15:0] DE,
  input  logic [15:0] HL,
  input  logic [15:0] IX,
  input  logic [15:0] IY,
  input  logic [7:0]  AC,
  input  logic        Z,
  input  logic        N,
  input  logic        P,
  input  logic        C,
`ifdef Z80_FMT_ALTREG_EN
  input  logic [15:0] BC_alt,
  input  logic [15:0] DE_alt,
  input  logic [15:0] HL_alt,
`endif
  output logic [7:0]  char_data,
  output logic [1:0]  char_row,
  output logic [4:0]  char_col,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        done
);

  fmt_state_t state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  snap_t      snap_q, snap_d, snap_in;
  logic [7:0] rom_char;
  logic       at_last;
  logic       at_row_end;

  always_comb begin
    snap_in    = '0;
    snap_in.pc = PC;
    snap_in.sp = SP;
    snap_in.bc = BC;
    snap_in.de = DE;
    snap_in.hl = HL;
    snap_in.ix = IX;
    snap_in.iy = IY;
    snap_in.ac = AC;
    snap_in.z  = Z;
    snap_in.n  = N;
    snap_in.p  = P;
    snap_in.c  = C;
`ifdef Z80_FMT_ALTREG_EN
    snap_in.bc_alt = BC_alt;
    snap_in.de_alt = DE_alt;
    snap_in.hl_alt = HL_alt;
`endif
  end

  // Index is kept as (row, col) directly so no divide is needed for the coordinates.
  assign at_row_end = (col_q == 5'(PANEL_COLS - 1));
  assign at_last    = at_row_end && (row_q == 2'(PANEL_ROWS - 1));

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = snap_in;
          row_d   = '0;
          col_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (char_ready) begin
          if (at_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = FINISH;
          end else if (at_row_end) begin
            row_d = row_q + 2'd1;
            col_d = '0;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      snap_q  <= snap_d;
    end
  end

  z80_fmt_charrom u_charrom (
    .row_i  (row_q),
    .col_i  (col_q),
    .snap_i (snap_q),
    .char_o (rom_char)
  );

  assign char_valid = (state_q == EMIT);
  assign char_data  = char_valid ? rom_char : ASC_SPACE;
  assign char_row   = row_q;
  assign char_col   = col_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);

endmodule

// File: tb/tb_z80_reg_formatter.sv
// Self-checking bench for z80_reg_formatter: table vectors, randomized panels vs a string-level model.
// Builds with or without Z80_FMT_ALTREG_EN.
module tb_z80_reg_formatter;

`ifdef Z80_FMT_ALTREG_EN
  localparam int NCH = 96;
`else
  localparam int NCH = 72;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] PC = '0, SP = '0, BC = '0, DE = '0, HL = '0, IX = '0, IY = '0;
  logic [7:0]  AC = '0;
  logic        Z = 1'b0, N = 1'b0, P = 1'b0, C = 1'b0;
`ifdef Z80_FMT_ALTREG_EN
  logic [15:0] BC_alt = '0, DE_alt = '0, HL_alt = '0;
`endif
  logic [7:0]  char_data;
  logic [1:0]  char_row;
  logic [4:0]  char_col;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        busy;
  logic        done;

  always #5 clk_sys = ~clk_sys;

  z80_reg_formatter dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .start      (start),
    .PC         (PC),
    .SP         (SP),
    .BC         (BC),
    .DE         (DE),
    .HL         (HL),
    .IX         (IX),
    .IY         (IY),
    .AC         (AC),
    .Z          (Z),
    .N          (N),
    .P          (P),
    .C          (C),
`ifdef Z80_FMT_ALTREG_EN
    .BC_alt     (BC_alt),
    .DE_alt     (DE_alt),
    .HL_alt     (HL_alt),
`endif
    .char_data  (char_data),
    .char_row   (char_row),
    .char_col   (char_col),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [15:0] pc, sp, bc, de, hl, ix, iy, bca, dea, hla;
    logic [7:0]  ac;
    logic        z, n, p, c;
  } regs_t;

  typedef struct {
    regs_t r;
    string row0;
    string row2;
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] got[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  function automatic void chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
  endfunction

  // Reference model: the panel as one string, built straight from the text layout.
  function automatic string hx(input logic [15:0] v, input int nd);
    string d;
    string s;
    int    k;
    d = "0123456789ABCDEF";
    s = "";
    for (int i = nd - 1; i >= 0; i--) begin
      k = int'((v >> (4 * i)) & 16'hF);
      s = {s, $sformatf("%c", d[k])};
    end
    return s;
  endfunction

  function automatic string fl(input logic b, input string letter);
    return b ? letter : "-";
  endfunction

  function automatic string model_panel(input regs_t r);
    string s;
    s = {"PC:", hx(r.pc, 4), " SP:", hx(r.sp, 4), " A:", hx({8'h00, r.ac}, 2), "    "};
    s = {s, "BC:", hx(r.bc, 4), " DE:", hx(r.de, 4), " HL:", hx(r.hl, 4), " "};
    s = {s, "IX:", hx(r.ix, 4), " IY:", hx(r.iy, 4), " F:",
         fl(r.z, "Z"), fl(r.n, "N"), fl(r.p, "P"), fl(r.c, "C"), "  "};
`ifdef Z80_FMT_ALTREG_EN
    s = {s, "BC'", hx(r.bca, 4), " DE'", hx(r.dea, 4), " HL'", hx(r.hla, 4), " "};
`endif
    return s;
  endfunction

  function automatic regs_t zero_regs();
    regs_t r;
    r.pc = '0; r.sp = '0; r.bc = '0; r.de = '0; r.hl = '0; r.ix = '0; r.iy = '0;
    r.bca = '0; r.dea = '0; r.hla = '0; r.ac = '0;
    r.z = 1'b0; r.n = 1'b0; r.p = 1'b0; r.c = 1'b0;
    return r;
  endfunction

  function automatic regs_t rand_regs();
    regs_t r;
    r.pc = 16'($urandom); r.sp = 16'($urandom); r.bc = 16'($urandom);
    r.de = 16'($urandom); r.hl = 16'($urandom); r.ix = 16'($urandom);
    r.iy = 16'($urandom); r.bca = 16'($urandom); r.dea = 16'($urandom);
    r.hla = 16'($urandom); r.ac = 8'($urandom);
    r.z = 1'($urandom); r.n = 1'($urandom); r.p = 1'($urandom); r.c = 1'($urandom);
    return r;
  endfunction

  task automatic apply_regs(input regs_t r);
    PC = r.pc; SP = r.sp; BC = r.bc; DE = r.de; HL = r.hl; IX = r.ix; IY = r.iy;
    AC = r.ac; Z = r.z; N = r.n; P = r.p; C = r.c;
`ifdef Z80_FMT_ALTREG_EN
    BC_alt = r.bca; DE_alt = r.dea; HL_alt = r.hla;
`endif
  endtask

  function automatic string got_row(input int row);
    string s;
    s = "";
    for (int c = 0; c < 24; c++)
      if (row * 24 + c < got.size()) s = {s, $sformatf("%c", got[row * 24 + c])};
    return s;
  endfunction

  task automatic check_panel(input string tag, input regs_t r);
    string      exp;
    int         errs;
    logic [7:0] e;
    exp  = model_panel(r);
    errs = 0;
    chk({tag, " char_count"}, 32'(got.size()), 32'(NCH));
    for (int i = 0; i < NCH && i < got.size(); i++) begin
      e = exp[i];
      if (got[i] !== e) errs++;
    end
    chk({tag, " panel_chars_wrong"}, 32'(errs), 32'd0);
  endtask

  // Pulses start at the following cycle N, then runs until done; done_cyc is cycles after N.
  task automatic run_panel(input bit rnd_ready, input bit disturb, input string tag,
                           output int done_cyc);
    logic [14:0] held;
    bit          stalled;
    int          idx;
    regs_t       junk;
    got.delete();
    done_cyc = -1;
    idx      = 0;
    stalled  = 1'b0;
    held     = '0;
    @(posedge clk_sys); #1;
    start      = 1'b1;
    char_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk_sys); #1;
      start = (disturb && cyc == 10);
      if (disturb && cyc == 5) begin
        junk = rand_regs();
        apply_regs(junk);
      end
      if (done) begin
        done_cyc = cyc;
        chk({tag, " busy_in_finish"}, 32'({busy, char_valid}), 32'b10);
        break;
      end
      chk({tag, " valid_busy"}, 32'({char_valid, busy}), 32'b11);
      if (cyc == 1) chk({tag, " first_char"}, 32'(char_data), 32'h50);
      if (stalled) chk({tag, " stall_hold"}, 32'({char_data, char_row, char_col}), 32'(held));
      chk({tag, " coord"}, 32'({char_row, char_col}), 32'({2'(idx / 24), 5'(idx % 24)}));
      char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (char_valid && char_ready) begin
        got.push_back(char_data);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      held = {char_data, char_row, char_col};
    end
    start      = 1'b0;
    char_ready = 1'b1;
    chk({tag, " done_seen"}, 32'(done_cyc != -1), 32'd1);
  endtask

  initial begin
    vec_t  tbl[3];
    regs_t r;
    int    dc;
    bit    hit;

    tbl[0].r = zero_regs();
    tbl[0].r.pc = 16'h1234; tbl[0].r.sp = 16'hFFFE; tbl[0].r.ac = 8'h3C;
    tbl[0].r.ix = 16'hABCD; tbl[0].r.iy = 16'h0000;
    tbl[0].r.z = 1'b1; tbl[0].r.p = 1'b1; tbl[0].r.hla = 16'h8001;
    tbl[0].r.bc = 16'h0F1E; tbl[0].r.de = 16'h2D3C; tbl[0].r.hl = 16'h4B5A;
    tbl[0].row0 = "PC:1234 SP:FFFE A:3C    ";
    tbl[0].row2 = "IX:ABCD IY:0000 F:Z-P-  ";
    tbl[1].r = zero_regs();
    tbl[1].r.pc = 16'h00A0; tbl[1].r.sp = 16'h9F0B; tbl[1].r.ac = 8'hFF;
    tbl[1].r.ix = 16'h0001; tbl[1].r.iy = 16'hFEDC;
    tbl[1].r.z = 1'b1; tbl[1].r.n = 1'b1; tbl[1].r.p = 1'b1; tbl[1].r.c = 1'b1;
    tbl[1].row0 = "PC:00A0 SP:9F0B A:FF    ";
    tbl[1].row2 = "IX:0001 IY:FEDC F:ZNPC  ";
    tbl[2].r = zero_regs();
    tbl[2].r.n = 1'b1; tbl[2].r.c = 1'b1;
    tbl[2].row0 = "PC:0000 SP:0000 A:00    ";
    tbl[2].row2 = "IX:0000 IY:0000 F:-N-C  ";

    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_ctrl", 32'({char_valid, busy, done}), 32'd0);
    chk("reset_data", 32'(char_data), 32'h20);
    chk("reset_coord", 32'({char_row, char_col}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    chk("idle_after_reset", 32'({char_valid, busy, done}), 32'd0);

    for (int t = 0; t < 3; t++) begin
      apply_regs(tbl[t].r);
      run_panel(1'b0, 1'b0, "tbl", dc);
      chk("tbl done_latency", 32'(dc), 32'(NCH + 1));
      chk_str("tbl row0", got_row(0), tbl[t].row0);
      chk_str("tbl row2", got_row(2), tbl[t].row2);
`ifdef Z80_FMT_ALTREG_EN
      if (t == 0) chk_str("tbl row3_tail", got_row(3).substr(16, 23), "HL'8001 ");
`endif
      check_panel("tbl", tbl[t].r);
      start = 1'b1;  // lands in FINISH and must be dropped
      @(posedge clk_sys); #1;
      start = 1'b0;
      chk("finish_start_ignored", 32'({char_valid, busy, done}), 32'd0);
      @(posedge clk_sys); #1;
      chk("still_idle", 32'({char_valid, busy}), 32'd0);
    end

    // Back-to-back: start in the first IDLE cycle after FINISH must be accepted.
    r = rand_regs();
    apply_regs(r);
    run_panel(1'b0, 1'b0, "b2b_a", dc);
    r = rand_regs();
    apply_regs(r);
    run_panel(1'b0, 1'b0, "b2b_b", dc);
    chk("b2b done_latency", 32'(dc), 32'(NCH + 1));
    check_panel("b2b", r);

    for (int k = 0; k < 4; k++) begin
      r = rand_regs();
      apply_regs(r);
      run_panel(1'b1, 1'b0, "rand", dc);
      check_panel("rand", r);
    end

    // Inputs change and a second start arrive mid-panel; panel must follow the snapshot.
    r = rand_regs();
    apply_regs(r);
    run_panel(1'b0, 1'b1, "disturb", dc);
    chk("disturb done_latency", 32'(dc), 32'(NCH + 1));
    check_panel("disturb", r);

    // Reset while index 40 is presented.
    r = rand_regs();
    apply_regs(r);
    @(posedge clk_sys); #1;
    start      = 1'b1;
    char_ready = 1'b1;
    hit        = 1'b0;
    for (int cyc = 1; cyc <= 200 && !hit; cyc++) begin
      @(posedge clk_sys); #1;
      start = 1'b0;
      if (char_valid && char_row == 2'd1 && char_col == 5'd16) begin
        hit     = 1'b1;
        reset_n = 1'b0;
      end
    end
    chk("rst reached_idx40", 32'(hit), 32'd1);
    @(posedge clk_sys); #1;
    chk("rst ctrl", 32'({char_valid, busy, done}), 32'd0);
    chk("rst data", 32'(char_data), 32'h20);
    chk("rst coord", 32'({char_row, char_col}), 32'd0);
    repeat (2) begin
      @(posedge clk_sys); #1;
      chk("rst no_done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk_sys); #1;
      chk("post_rst idle", 32'({char_valid, done}), 32'd0);
    end
    r = rand_regs();
    apply_regs(r);
    run_panel(1'b1, 1'b0, "after_rst", dc);
    check_panel("after_rst", r);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/z80_reg_formatter.md
# z80_reg_formatter

Downstream consumer of the Z80 register debugger outputs. On a start pulse it snapshots the captured register values, then streams them out as fixed-layout ASCII characters with row and column coordinates over a valid/ready handshake. The intended sink is an on-screen debug overlay or character buffer writer. It converts binary register state into a readable text panel, one character per accepted transfer.

## Interface
- No parameters; layout constants live in the package.
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to snapshot and emit a panel
- PC, SP, BC, DE, HL, IX, IY  in  16 each  register values from debugger
- AC  in  8  accumulator
- Z, N, P, C  in  1 each  flag bits
- char_data  out  8  ASCII character
- char_row  out  2  panel row 0..3
- char_col  out  5  panel column 0..23
- char_valid  out  1  character presented
- char_ready  in  1  sink accepts when high with char_valid
- busy  out  1  panel emission in progress
- done  out  1  one-cycle pulse after the last character is accepted
- BC_alt, DE_alt, HL_alt  in  16 each  present only with Z80_FMT_ALTREG_EN

## Operation
- States are IDLE, EMIT and FINISH.
- **IDLE:** when start=1, latch all inputs into a snapshot, clear the index to 0, and go to EMIT. The snapshot is frozen until the next accepted start.
- **EMIT:** char_valid=1. char_data, row and col are derived from the index: row=index/24, col=index%24.
  - On char_valid&&char_ready, the index increments.
  - On acceptance of the last index (71, or 95 with the macro), go to FINISH.
  - Outputs stay stable while char_ready=0.
- **FINISH:** done=1 for one cycle, then go to IDLE.
- Layout uses uppercase hex, MSB nibble first. Short rows are padded with spaces (0x20) to 24 columns.
  - Row 0: "PC:hhhh SP:hhhh A:hh" + 4 spaces.
  - Row 1: "BC:hhhh DE:hhhh HL:hhhh" + 1 space.
  - Row 2: "IX:hhhh IY:hhhh F:" then four flag chars in order Z N P C, then 2 spaces. A flag char is its letter when the flag is set and '-' when clear.
- Nibble to ASCII: 0–9 map to 0x30+n; A–F map to 0x41+(n-10).
- start while busy=1, including FINISH, is ignored and not queued.
- busy=1 in EMIT and FINISH.

## Timing
- Reset values: char_valid=0, busy=0, done=0, char_data=0x20, char_row=0, char_col=0, index=0. State is IDLE and the snapshot is cleared to 0.
- start sampled at cycle N:
  - the snapshot is taken at the edge ending N;
  - char_valid=1 with index 0 ("P") in cycle N+1.
- Throughput is 1 character per cycle while char_ready is held high, with no bubbles between characters.
- Full 72-char panel with ready held high: start at N, last handshake at N+72, done at N+73, busy=0 and IDLE at N+74. A start at N+74 is accepted.
- Backpressure: while char_valid=1 and char_ready=0, char_data/row/col are held unchanged.
- reset_n low mid-panel aborts at the next edge: all outputs return to reset values and done is not pulsed.
- Input changes after the snapshot edge never affect the panel in progress.

## Configuration
- Z80_FMT_ALTREG_EN defined:
  - adds the BC_alt, DE_alt and HL_alt ports and their snapshot;
  - adds row 3: "BC'hhhh DE'hhhh HL'hhhh" + 1 space;
  - the panel is 96 characters and the last index is 95.
- Undefined: the ports do not exist, the panel is 72 characters and the last index is 71.

## Structure
- Package z80_dbg_pkg holds:
  - PANEL_COLS=24;
  - PANEL_ROWS (3 or 4, selected by the macro);
  - PANEL_LAST;
  - the ASCII constants (space, colon, '-', apostrophe);
  - the state enum typedef fmt_state_t;
  - a packed snapshot struct typedef.
- One sub-module, z80_fmt_charrom: combinational mapping from (row, col, snapshot) to char_data, including nibble-to-ASCII. The top module holds the FSM, counters and handshake.

## Test plan
- PC=0x1234, SP=0xFFFE, AC=0x3C, ready held high, pulse start -> row 0 reads "PC:1234 SP:FFFE A:3C    "; done exactly 73 cycles after start.
- Z=1, N=0, P=1, C=0, IX=0xABCD, IY=0x0000 -> row 2 reads "IX:ABCD IY:0000 F:Z-P-  ".
- Toggle char_ready randomly with 50% duty -> every character appears exactly once; data, row and col are stable during every stall; index order is 0..71.
- Pulse start again at cycle N+10 of an active panel, and change PC mid-panel -> the second start is ignored and the panel shows the original PC value.
- Drop reset_n at index 40 -> next cycle char_valid=0 and busy=0; no done pulse; a new start gives a full panel from "P".
- With Z80_FMT_ALTREG_EN, HL_alt=0x8001 -> row 3 ends "HL'8001 "; done follows the handshake at index 95.
